mux_rr_mem: RTL
===============

Name: mux_rr_mem

Overview:
Parametrised N-channel, WIDTH-bit registered multiplexer. It is the successor of the 2:1 registered mux.
- Two selection modes: fixed selection by index, or round-robin among valid channels.
- Per-channel valid/ready handshake on the inputs and a valid/ready handshake on the output, with 1-cycle latency and full throughput.
- Sits between several producer blocks and a single consumer.

Parameters:
WIDTH, 2, data bits per channel
CHANNELS, 4, number of input channels (>=2)
SEL_W, $clog2(CHANNELS), localparam, index width (not overridable)

Ports:
clk  input  1  rising-edge clock
reset_L  input  1  asynchronous active-low reset
mode  input  1  0 = fixed select, 1 = round-robin
selector  input  SEL_W  channel index used when mode=0
valid_in  input  CHANNELS  per-channel data valid
data_in  input  CHANNELS*WIDTH  packed data; channel i at [i*WIDTH +: WIDTH]
in_ready  output  CHANNELS  one-hot accept strobe, combinational
ready  input  1  downstream ready for data_out
data_out  output  WIDTH  registered data
valid_out  output  1  registered valid
chan_out  output  SEL_W  registered index of the channel in data_out

Behaviour:
- Reset: reset_L=0 clears state immediately, independent of clk. data_out=0, valid_out=0, chan_out=0, rr_ptr=0. rr_ptr is an internal SEL_W-bit round-robin priority pointer.
- Reset mid-transfer: the captured word is discarded and no handshake completes. After reset_L rises, the first edge behaves as from idle.
- load_en = !valid_out | ready. The output register accepts a new word only when load_en=1.
- Grant, mode=0: grant is selector when valid_in[selector]=1. No grant if that channel is not valid or selector >= CHANNELS. rr_ptr is not modified.
- Grant, mode=1: scan channels rr_ptr, rr_ptr+1, …, wrapping modulo CHANNELS. Grant the first channel with valid_in=1. No grant if valid_in is all zero.
- in_ready[g] = load_en & grant_valid for the granted channel g; all other bits are 0. in_ready is combinational and at most one bit is set. A transfer on channel g completes when valid_in[g] & in_ready[g] at a clock edge.
- At a clk edge with load_en & grant_valid:
  - data_out <= channel g data, chan_out <= g, valid_out <= 1.
  - If mode=1: rr_ptr <= (g+1) mod CHANNELS (wraps; handles non-power-of-2 CHANNELS).
- At a clk edge with load_en & !grant_valid: valid_out <= 0. data_out, chan_out and rr_ptr hold.
- At a clk edge with !load_en (output valid and stalled): all registers hold and in_ready=0.
- Latency: data is accepted at edge k and appears on data_out after edge k. Back-to-back words are sustained while ready=1.
- Mode and selector changes act combinationally in the same cycle. Switching modes does not reset rr_ptr.
- Simultaneous ready=1 and a new grant: the old word completes its output handshake and the new word loads in the same edge.
- Sampling with X/undefined inputs is not required. valid_in bits of non-granted channels have no effect.

Test Plan:
1. Async reset: run traffic, drop reset_L between clock edges → data_out=0, valid_out=0, chan_out=0 immediately. After release, all-valid RR traffic grants channel 0 first.
2. Fixed mode (WIDTH=2, CHANNELS=4): mode=0, selector=2, valid_in=4'b0100, ch2=2'b11, ready=1 → in_ready=4'b0100. Next edge: data_out=2'b11, valid_out=1, chan_out=2. Then selector=1 with valid_in[1]=0 → in_ready=0 and valid_out=0 after the next edge.
3. RR fairness: mode=1, valid_in=4'b1111, distinct data per channel, ready=1 for 8 cycles → chan_out sequence 0,1,2,3,0,1,2,3 with matching data and valid_out=1 throughout.
4. RR skip and wrap: rr_ptr=3, valid_in=4'b0011 → grant channel 0 and rr_ptr becomes 1. Next cycle, same valid_in → grant channel 1 and rr_ptr becomes 2.
5. Backpressure: valid_out=1, ready=0 for 3 cycles with valid_in=4'b1111 → data_out, chan_out and rr_ptr are stable and in_ready=0. Then ready=1 → the next channel in RR order loads on that edge.
6. Idle and non-power-of-2: CHANNELS=3, all valid, ready=1 → chan_out 0,1,2,0. Then valid_in=0 → valid_out=0 next edge, with data_out holding its last value.

Source files
------------

// File: rtl/mux_rr_mem.sv
// N-channel registered multiplexer with fixed-index or round-robin channel selection.
// Latency: 1 cycle. A word accepted at edge k is on data_out after edge k, at full throughput.
// Backpressure: while valid_out=1 and ready=0 the output holds and in_ready stays all-zero.
//
// Ports:
//   clk, reset_L         rising-edge clock, asynchronous active-low reset
//   mode, selector       0 = fixed channel `selector`, 1 = round-robin among valid channels
//   valid_in, data_in    per-channel valid and packed data (channel i at [i*WIDTH +: WIDTH])
//   in_ready             one-hot combinational accept strobe toward the producers
//   ready                downstream ready for data_out
//   data_out, valid_out, chan_out   registered word, its valid and its source channel
module mux_rr_mem #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          selector,
  input  logic [CHANNELS-1:0]       valid_in,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      ready,
  output logic [WIDTH-1:0]          data_out,
  output logic                      valid_out,
  output logic [SEL_W-1:0]          chan_out
);

  // Channel count and last index at the widths they are compared against.
  localparam logic [SEL_W:0]   CH_EXT  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS-1);

  logic [WIDTH-1:0]    r_dat;
  logic                r_vld;
  logic [SEL_W-1:0]    r_chan;
  logic [SEL_W-1:0]    r_rr_ptr;

  logic                w_load_en;
  logic                w_grant_vld;
  logic [SEL_W-1:0]    w_grant;
  logic [SEL_W:0]      w_scan;
  logic [WIDTH-1:0]    w_dat;
  logic [CHANNELS-1:0] w_in_rdy;
  logic [SEL_W-1:0]    w_rr_next;

  // The output register can take a word when it is empty or being drained this edge.
  assign w_load_en = !r_vld || ready;

  // Grant selection. In round-robin mode the scan starts at r_rr_ptr; one extra bit on
  // the scan index lets the wrap work for non-power-of-2 channel counts (rr_ptr is
  // always below CHANNELS, so a single subtraction brings it back into range).
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_scan      = '0;
    if (!mode) begin
      // A selector at or beyond CHANNELS matches no loop index, so nothing is granted.
      for (int i = 0; i < CHANNELS; i++) begin
        if (selector == SEL_W'(i) && valid_in[i]) begin
          w_grant_vld = 1'b1;
          w_grant     = SEL_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        w_scan = {1'b0, r_rr_ptr} + (SEL_W+1)'(i);
        if (w_scan >= CH_EXT) begin
          w_scan = w_scan - CH_EXT;
        end
        if (!w_grant_vld && valid_in[w_scan[SEL_W-1:0]]) begin
          w_grant_vld = 1'b1;
          w_grant     = w_scan[SEL_W-1:0];
        end
      end
    end
  end

  // Data of the granted channel.
  always_comb begin
    w_dat = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_grant == SEL_W'(i)) begin
        w_dat = data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // One-hot accept strobe. Held low during reset so no producer sees a handshake
  // that the output register would then drop.
  always_comb begin
    w_in_rdy = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_in_rdy[i] = reset_L && w_load_en && w_grant_vld && (w_grant == SEL_W'(i));
    end
  end

  assign w_rr_next = (w_grant == LAST_CH) ? '0 : w_grant + SEL_W'(1);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_dat    <= '0;
      r_vld    <= 1'b0;
      r_chan   <= '0;
      r_rr_ptr <= '0;
    end else if (w_load_en) begin
      if (w_grant_vld) begin
        r_dat  <= w_dat;
        r_chan <= w_grant;
        r_vld  <= 1'b1;
        if (mode) begin
          r_rr_ptr <= w_rr_next;
        end
      end else begin
        r_vld <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_rdy;
  assign data_out  = r_dat;
  assign valid_out = r_vld;
  assign chan_out  = r_chan;

endmodule
